serial_word_tx: RTL and testbench

Parallel-in, serial-out word transmitter with a small input buffer and a valid/ready upload port. It accepts W-bit words from a producer and shifts them out MSB first, one bit per enabled clock. It also drives first/last bit framing strobes so that serial-in receivers in this design can realign on word boundaries. The block is the transmit end of the design's serial bit links.

---
 rtl/serial_pkg.sv | 14 +
 rtl/serial_tx_fifo.sv | 61 ++++++
 rtl/serial_word_tx.sv | 100 ++++++++++
 tb/tb_serial_word_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit-link transmit and receive blocks.
// Holds the default word width, the transmitter FSM encoding and the bit order.
package serial_pkg;

    localparam int unsigned W_DEFAULT = 4;

    localparam bit MSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_t;

endpackage

// File: rtl/serial_tx_fifo.sv
// Show-ahead synchronous FIFO feeding the serial transmitter shift register.
// dout always presents the head word; pushes when full and pops when empty are ignored.
module serial_tx_fifo #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out word transmitter with first/last framing strobes.
// Words are buffered in a small FIFO and shifted out one bit per CS=1 edge.
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     CS,
    input  logic [W-1:0]             in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     sout_first,
    output logic                     sout_last,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    tx_state_t     state;
    logic [W-1:0]  shreg;
    logic [CW-1:0] bitcnt;

    logic [W-1:0]  head;
    logic          full;
    logic          empty;
    logic          push;
    logic          load;
    logic          at_last;

    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign at_last  = (state == SHIFT) && (bitcnt == LAST);

    // A load both fills shreg and pops the head, so it is the FIFO's only pop source.
    always_comb begin
        load = 1'b0;
        if (CS && !empty && ((state == IDLE) || at_last)) begin
            load = 1'b1;
        end
    end

    serial_tx_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (load),
        .din   (in_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
        end else if (CS) begin
            if (load) begin
                shreg  <= head;
                bitcnt <= '0;
                state  <= SHIFT;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    SHIFT: begin
                        if (bitcnt != LAST) begin
                            shreg  <= MSB_FIRST ? {shreg[W-2:0], 1'b0} : {1'b0, shreg[W-1:1]};
                            bitcnt <= bitcnt + 1'b1;
                        end else begin
                            shreg  <= '0;
                            bitcnt <= '0;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // shreg is cleared whenever the FSM is idle, so sout needs no state qualification.
    assign sout       = MSB_FIRST ? shreg[W-1] : shreg[0];
    assign sout_valid = (state == SHIFT);
    assign sout_first = (state == SHIFT) && (bitcnt == '0);
    assign sout_last  = at_last;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed self-checking bench for serial_word_tx (W=4, DEPTH=2).
// A per-cycle vector table covers the single-word and back-to-back cases; hand sequences cover the rest.
module tb_serial_word_tx;

    logic       clk;
    logic       rst;
    logic       CS;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sout;
    logic       sout_valid;
    logic       sout_first;
    logic       sout_last;
    logic [1:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    serial_word_tx #(
        .W     (4),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .CS         (CS),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_first (sout_first),
        .sout_last  (sout_last),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       cs;
        logic       valid;
        logic [3:0] din;
        logic       e_sout;
        logic       e_sv;
        logic       e_first;
        logic       e_last;
        logic [1:0] e_level;
        logic       e_ready;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic e_sout, input logic e_sv,
                              input logic e_first, input logic e_last, input logic [1:0] e_level,
                              input logic e_ready);
        check({tag, "_sout"},  32'(sout),       32'(e_sout));
        check({tag, "_valid"}, 32'(sout_valid), 32'(e_sv));
        check({tag, "_first"}, 32'(sout_first), 32'(e_first));
        check({tag, "_last"},  32'(sout_last),  32'(e_last));
        check({tag, "_level"}, 32'(level),      32'(e_level));
        check({tag, "_ready"}, 32'(in_ready),   32'(e_ready));
    endtask

    // Gathers n valid bits starting from the currently visible one, CS must be 1.
    task automatic collect(input int n, output logic [31:0] bits, output int got);
        bits = '0;
        got  = 0;
        for (int c = 0; c < 64 && got < n; c++) begin
            if (sout_valid) begin
                bits = {bits[30:0], sout};
                got++;
            end
            if (got < n) tick();
        end
    endtask

    initial begin
        logic [31:0] bits;
        int          got;

        //              rst   cs    vld   din    sout  sv    first last  lvl   rdy
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};

        rst      = 1'b1;
        CS       = 1'b0;
        in_data  = 4'h0;
        in_valid = 1'b0;
        @(negedge clk);
        tick();

        // Single word 1011 followed by back-to-back A,5.
        for (int i = 0; i < 17; i++) begin
            rst      = vecs[i].rst;
            CS       = vecs[i].cs;
            in_valid = vecs[i].valid;
            in_data  = vecs[i].din;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_sout, vecs[i].e_sv, vecs[i].e_first,
                       vecs[i].e_last, vecs[i].e_level, vecs[i].e_ready);
        end

        // Backpressure: CS low, three pushes, third held until a pop frees space.
        CS = 1'b0; in_valid = 1'b1; in_data = 4'h9;
        tick();
        check("bp_level1", 32'(level), 32'd1);
        in_data = 4'h6;
        tick();
        check("bp_level2", 32'(level), 32'd2);
        check("bp_ready_full", 32'(in_ready), 32'd0);
        in_data = 4'hE;
        tick();
        tick();
        check("bp_level_held", 32'(level), 32'd2);
        check("bp_ready_held", 32'(in_ready), 32'd0);
        CS = 1'b1;
        tick();
        check_outs("bp_load", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
        tick();
        check("bp_third_in", 32'(level), 32'd2);
        in_valid = 1'b0;
        collect(11, bits, got);
        check("bp_bit_count", 32'(got), 32'd11);
        check("bp_stream", bits, 32'b001_0110_1110);
        tick();
        check("bp_idle", 32'(sout_valid), 32'd0);
        check("bp_empty", 32'(level), 32'd0);

        // CS gating in the middle of 1101.
        in_valid = 1'b1; in_data = 4'hD;
        tick();
        in_valid = 1'b0;
        tick();
        check_outs("cs_bit0", 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        tick();
        check_outs("cs_bit1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        CS = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_outs($sformatf("cs_hold%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        end
        CS = 1'b1;
        tick();
        check_outs("cs_bit2", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        tick();
        check_outs("cs_bit3", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
        tick();
        check_outs("cs_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        // Reset at bit 2 of 1100 with 7 buffered, then 0011 after release.
        in_valid = 1'b1; in_data = 4'hC;
        tick();
        in_data = 4'h7;
        tick();
        check_outs("rst_load", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
        in_valid = 1'b0;
        tick();
        tick();
        check_outs("rst_bit2", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
        rst = 1'b1;
        tick();
        check_outs("rst_flush", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0; in_valid = 1'b1; in_data = 4'h3;
        tick();
        in_valid = 1'b0;
        tick();
        collect(4, bits, got);
        check("rst_bit_count", 32'(got), 32'd4);
        check("rst_stream", bits, 32'b0011);
        tick();
        check_outs("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        // Push on the load edge while one word is buffered.
        CS = 1'b0; in_valid = 1'b1; in_data = 4'h2;
        tick();
        check("pp_level_pre", 32'(level), 32'd1);
        CS = 1'b1; in_data = 4'hB;
        tick();
        check_outs("pp_load", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
        in_valid = 1'b0;
        tick();
        collect(7, bits, got);
        check("pp_bit_count", 32'(got), 32'd7);
        check("pp_stream", bits, 32'b010_1011);
        tick();
        check_outs("pp_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
